// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debouncer: board clock and FSM state encoding.
package sw_debounce_pkg;

    localparam int unsigned BOARD_CLK_HZ = 125_000_000;

    localparam logic [1:0] ENC_RELEASED     = 2'd0;
    localparam logic [1:0] ENC_PRESS_PEND   = 2'd1;
    localparam logic [1:0] ENC_PRESSED      = 2'd2;
    localparam logic [1:0] ENC_RELEASE_PEND = 2'd3;

    typedef enum logic [1:0] {
        ST_RELEASED     = ENC_RELEASED,
        ST_PRESS_PEND   = ENC_PRESS_PEND,
        ST_PRESSED      = ENC_PRESSED,
        ST_RELEASE_PEND = ENC_RELEASE_PEND
    } state_t;

endpackage

// File: rtl/sw_debounce_sync_chain.sv
// Multi-flop synchroniser for asynchronous board inputs; nothing sits before the first flop.
module sync_chain
    import sw_debounce_pkg::*;
#(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    // Shift the raw input through the flop chain; reset loads the idle value everywhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= RST_VAL;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/sw_debounce.sv
// Push-switch conditioner: synchronise, debounce, and emit press/release/long-press strobes.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned CLK_HZ          = BOARD_CLK_HZ,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = CLK_HZ / 100,
    parameter int unsigned LONG_CYCLES     = CLK_HZ,
    parameter logic        IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic sw_clean,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned    DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned    HOLD_W   = $clog2(LONG_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    logic w_sync;
    logic w_holding;

    state_t            r_state;
    logic [DB_W-1:0]   r_db_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_clean;
    logic              r_pressed;
    logic              r_press_pulse;
    logic              r_release_pulse;
    logic              r_long_pulse;

    sync_chain #(
        .WIDTH   (1),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (IDLE_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (sw_raw),
        .o_q (w_sync)
    );

    // The long-press timer runs while the committed level is "pressed", including a pending release.
    assign w_holding = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_PEND);

    // Debounce FSM with registered level and one-cycle strobes; any reversion restarts the wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_RELEASED;
            r_db_cnt        <= '0;
            r_hold_cnt      <= '0;
            r_clean         <= IDLE_LEVEL;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;

            // Saturating hold timer; the strobe fires on the single step that reaches the limit.
            if (w_holding && (r_hold_cnt != HOLD_MAX)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
                if (r_hold_cnt == (HOLD_MAX - 1'b1)) begin
                    r_long_pulse <= 1'b1;
                end
            end

            case (r_state)
                ST_RELEASED: begin
                    if (w_sync != IDLE_LEVEL) begin
                        r_state  <= ST_PRESS_PEND;
                        r_db_cnt <= '0;
                    end
                end
                ST_PRESS_PEND: begin
                    if (w_sync == IDLE_LEVEL) begin
                        r_state <= ST_RELEASED;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state       <= ST_PRESSED;
                        r_clean       <= ~IDLE_LEVEL;
                        r_pressed     <= 1'b1;
                        r_press_pulse <= 1'b1;
                        r_hold_cnt    <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (w_sync == IDLE_LEVEL) begin
                        r_state  <= ST_RELEASE_PEND;
                        r_db_cnt <= '0;
                    end
                end
                ST_RELEASE_PEND: begin
                    if (w_sync != IDLE_LEVEL) begin
                        r_state <= ST_PRESSED;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state         <= ST_RELEASED;
                        r_clean         <= IDLE_LEVEL;
                        r_pressed       <= 1'b0;
                        r_release_pulse <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RELEASED;
                end
            endcase
        end
    end

    assign sw_clean      = r_clean;
    assign pressed       = r_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign long_pulse    = r_long_pulse;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: a run-length reference model queues expected outputs per edge,
// and a monitor on the falling edge pops and compares them against the DUT.
module tb_sw_debounce;

    localparam int unsigned SYNC_S = 2;
    localparam int unsigned DB     = 4;
    localparam int unsigned LONG   = 10;
    localparam logic        IDLE   = 1'b1;

    typedef struct packed {
        logic clean;
        logic prs;
        logic pp;
        logic rp;
        logic lp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw_raw = 1'b0;
    logic sw_clean, pressed, press_pulse, release_pulse, long_pulse;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    exp_t q[$];

    sw_debounce #(
        .CLK_HZ          (1000),
        .SYNC_STAGES     (SYNC_S),
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LONG),
        .IDLE_LEVEL      (IDLE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sw_raw        (sw_raw),
        .sw_clean      (sw_clean),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference model: the debounced level commits once the synchronised pin has differed from it
    // on DB+1 consecutive edges; a long press is due exactly LONG edges after the press edge.
    logic m_sync [SYNC_S];
    logic m_clean = IDLE;
    int   m_run = 0;
    int   m_n = 0;
    int   m_press_edge = 0;
    bit   m_armed = 0;

    always @(posedge clk) begin
        exp_t e;
        logic seen;
        m_n++;
        e = '0;
        if (rst) begin
            for (int i = 0; i < SYNC_S; i++) m_sync[i] = IDLE;
            m_clean = IDLE;
            m_run   = 0;
            m_armed = 0;
        end else begin
            seen = m_sync[SYNC_S-1];
            for (int i = SYNC_S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = sw_raw;
            if (m_armed && (m_n == m_press_edge + int'(LONG))) begin
                e.lp    = 1'b1;
                m_armed = 0;
            end
            if (seen !== m_clean) m_run++;
            else m_run = 0;
            if (m_run == int'(DB) + 1) begin
                m_clean = seen;
                m_run   = 0;
                if (m_clean != IDLE) begin
                    e.pp         = 1'b1;
                    m_press_edge = m_n;
                    m_armed      = 1;
                end else begin
                    e.rp    = 1'b1;
                    m_armed = 0;
                end
            end
        end
        e.clean = m_clean;
        e.prs   = (m_clean != IDLE);
        q.push_back(e);
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare every registered output against the queued expectation for the last edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("sw_clean", sw_clean, e.clean);
            check("pressed", pressed, e.prs);
            check("press_pulse", press_pulse, e.pp);
            check("release_pulse", release_pulse, e.rp);
            check("long_pulse", long_pulse, e.lp);
            check("press_release_exclusive", press_pulse & release_pulse, 1'b0);
        end
    end

    task automatic hold(input logic lvl, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            sw_raw = lvl;
            rst    = r;
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        logic lvl;
        // Reset with the switch already held, then a full long press.
        hold(1'b0, 1'b1, 3);
        hold(1'b0, 1'b0, 20);
        hold(1'b1, 1'b0, 15);
        // Bounce on the press edge.
        hold(1'b0, 1'b0, 3);
        hold(1'b1, 1'b0, 1);
        hold(1'b0, 1'b0, 12);
        hold(1'b1, 1'b0, 12);
        // Short press: release commits before the long-press edge.
        hold(1'b0, 1'b0, 8);
        hold(1'b1, 1'b0, 12);
        // Release committing on the very edge the long press is due.
        hold(1'b0, 1'b0, 10);
        hold(1'b1, 1'b0, 12);
        // Reset mid-pending and mid-pressed with the switch held throughout.
        hold(1'b0, 1'b0, 4);
        hold(1'b0, 1'b1, 1);
        hold(1'b0, 1'b0, 12);
        hold(1'b0, 1'b1, 1);
        hold(1'b0, 1'b0, 10);
        hold(1'b1, 1'b0, 12);
        // Randomised bouncing, holds and occasional resets.
        lvl = 1'b1;
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 29) == 0) begin
                hold(lvl, 1'b1, int'($urandom_range(1, 2)));
            end else begin
                lvl = 1'($urandom_range(0, 1));
                hold(lvl, 1'b0, int'($urandom_range(1, 20)));
            end
        end
        hold(1'b1, 1'b0, 20);
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
